conv_kxk_stream: RTL
====================

// Module: conv_kxk_stream
// PURPOSE
//  Parametrised streaming KxK convolution MAC: loads K*K signed weights, then consumes one
//  window of K*K pixels per output, adds an incoming partial sum, saturates to O_BW and
//  optionally applies ReLU. Time-multiplexed (one multiplier) successor of the fixed 3x3 PE
//  chain; sits between the line-buffer/window generator and the channel accumulator.
// PARAMETERS
//  K      3   kernel side; TAPS = K*K weights/pixels per window
//  X_BW   8   signed pixel width
//  W_BW   8   signed weight width
//  I_BW   19  signed input partial-sum width
//  O_BW   19  signed saturated output width
// PORTS
//  i_clk      in   1      clock, rising edge
//  i_rst      in   1      asynchronous, active-high reset
//  i_w_load   in   1      pulse: start (re)loading weights
//  i_w_valid  in   1      weight beat valid (LOAD state only)
//  i_w        in   W_BW   weight, tap order 0..TAPS-1 (row-major)
//  i_x_valid  in   1      pixel beat valid
//  o_x_ready  out  1      pixel beat accepted when i_x_valid & o_x_ready
//  i_x        in   X_BW   pixel, same tap order as weights
//  i_psum     in   I_BW   partial sum, sampled with tap-0 pixel
//  i_relu     in   1      ReLU enable, sampled with tap-0 pixel
//  o_y_valid  out  1      output valid, held until accepted
//  i_y_ready  in   1      downstream accept
//  o_y        out  O_BW   saturated (optionally ReLU'd) result
//  o_w_ready  out  1      high in RUN: weight set complete
// BEHAVIOUR
//  Reset: state=IDLE, all weights=0, tap counters=0, acc=0; o_x_ready=0, o_y_valid=0, o_y=0,
//   o_w_ready=0.
//  FSM: IDLE --i_w_load--> LOAD; LOAD --TAPS-th accepted weight--> RUN; any state --i_w_load--> LOAD.
//   LOAD: each i_w_valid cycle writes w[w_cnt], w_cnt++; i_x ignored, o_x_ready=0.
//   i_w_load in RUN aborts any partial window (x_cnt=0, acc discarded); held output unaffected.
//   i_w_load and i_w_valid in same cycle: counter clears, beat is written as tap 0.
//  Arithmetic: ACC_BW = max(I_BW, X_BW+W_BW) + clog2(TAPS) + 1, full signed, never wraps.
//   tap 0 accept: acc <= sext(i_psum) + i_x*w[0]; relu_q <= i_relu.
//   tap n accept: acc <= acc + i_x*w[n]; x_cnt wraps TAPS-1 -> 0.
//  Output: on last-tap accept, r = sat(acc + i_x*w[TAPS-1]) clamped to
//   [-2^(O_BW-1), 2^(O_BW-1)-1]; if relu_q and r<0 then r=0. o_y<=r, o_y_valid<=1 next edge.
//   Latency: last-tap accept edge -> o_y_valid high after that edge (1 cycle).
//  Handshake: o_y/o_y_valid stable while o_y_valid & !i_y_ready. Drained on valid&ready.
//   o_x_ready = (state==RUN) & !(x_cnt==TAPS-1 & o_y_valid & !i_y_ready): only the last tap
//   stalls; same-cycle drain + last-tap accept is legal (back-to-back windows, no bubble).
//  TAPS=1 legal: every pixel is last tap. Throughput: 1 window per TAPS accepted beats.
// TESTING
//  1 K=3, w all 1, psum=0, x=1..9 -> o_y=45, o_y_valid one cycle after 9th accept.
//  2 w=127, x=127 x9, psum=200000 -> exact 345161 saturates o_y=262143; x=-128, psum=-200000
//    -> o_y=-262144.
//  3 w=1, x=-1 x9, psum=4, i_relu=1 -> o_y=0; same with i_relu=0 -> o_y=-5.
//  4 i_y_ready=0, two windows -> 2nd window stalls at tap 8 (o_x_ready=0), o_y holds 1st result;
//    raise i_y_ready -> 1st drains, tap 8 accepted same cycle, 2nd result next cycle.
//  5 i_w_load after 4 taps -> partial discarded, 9 new weights (w=2), x=1..9 -> o_y=90.
//  6 assert i_rst mid-window with o_y_valid=1 -> all outputs 0 immediately, o_x_ready=0 until reload.

Source files
------------

// File: rtl/conv_kxk_stream_if.sv
// Streaming handshake bundle for the KxK convolution MAC: weight load, pixel/psum input, result output.
interface conv_kxk_stream_if #(
  parameter int X_BW = 8,
  parameter int W_BW = 8,
  parameter int I_BW = 19,
  parameter int O_BW = 19
);
  logic                   i_w_load;
  logic                   i_w_valid;
  logic signed [W_BW-1:0] i_w;
  logic                   i_x_valid;
  logic                   o_x_ready;
  logic signed [X_BW-1:0] i_x;
  logic signed [I_BW-1:0] i_psum;
  logic                   i_relu;
  logic                   o_y_valid;
  logic                   i_y_ready;
  logic signed [O_BW-1:0] o_y;
  logic                   o_w_ready;

  modport master (
    output i_w_load, i_w_valid, i_w, i_x_valid, i_x, i_psum, i_relu, i_y_ready,
    input  o_x_ready, o_y_valid, o_y, o_w_ready
  );

  modport slave (
    input  i_w_load, i_w_valid, i_w, i_x_valid, i_x, i_psum, i_relu, i_y_ready,
    output o_x_ready, o_y_valid, o_y, o_w_ready
  );
endinterface

// File: rtl/conv_kxk_stream.sv
// Time-multiplexed KxK convolution MAC: one multiplier, one window of K*K pixels per output,
// partial-sum add, saturation to O_BW and optional ReLU, with valid/ready on pixels and results.
module conv_kxk_stream #(
  parameter int K    = 3,
  parameter int X_BW = 8,
  parameter int W_BW = 8,
  parameter int I_BW = 19,
  parameter int O_BW = 19
) (
  input  logic                i_clk,
  input  logic                i_rst,
  conv_kxk_stream_if.slave    bus
);

  localparam int TAPS   = K * K;
  localparam int CW     = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int P_BW   = X_BW + W_BW;
  localparam int ACC_BW = ((I_BW > P_BW) ? I_BW : P_BW) + $clog2(TAPS) + 1;
  localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);
  localparam logic signed [ACC_BW-1:0] SAT_MAX = {{(ACC_BW-O_BW+1){1'b0}}, {(O_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] SAT_MIN = {{(ACC_BW-O_BW+1){1'b1}}, {(O_BW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                   state_q;
  logic signed [W_BW-1:0]   w_q [TAPS];
  logic [CW-1:0]            w_cnt_q;
  logic [CW-1:0]            x_cnt_q;
  logic signed [ACC_BW-1:0] acc_q;
  logic                     relu_q;
  logic signed [O_BW-1:0]   y_q;
  logic                     y_vld_q;

  function automatic logic signed [O_BW-1:0] sat_fn(input logic signed [ACC_BW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[O_BW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[O_BW-1:0];
    else                  return v[O_BW-1:0];
  endfunction

  function automatic logic signed [O_BW-1:0] relu_fn(input logic signed [O_BW-1:0] v,
                                                     input logic en);
    if (en && v < 0) return '0;
    else             return v;
  endfunction

  logic                     x_last;
  logic                     y_stall;
  logic                     x_rdy;
  logic                     x_fire;
  logic                     w_fire;
  logic [CW-1:0]            w_idx;
  logic signed [W_BW-1:0]   w_sel;
  logic signed [P_BW-1:0]   prod;
  logic signed [ACC_BW-1:0] acc_d;
  logic                     relu_d;
  logic signed [O_BW-1:0]   y_d;

  // Tap 0 seeds the accumulator with the partial sum; the last tap feeds the output directly.
  always_comb begin
    x_last  = (x_cnt_q == LAST_TAP);
    y_stall = y_vld_q & ~bus.i_y_ready;
    x_rdy   = (state_q == RUN) & ~(x_last & y_stall);
    x_fire  = bus.i_x_valid & x_rdy & ~bus.i_w_load;
    w_fire  = bus.i_w_valid & (bus.i_w_load | (state_q == LOAD));
    w_idx   = bus.i_w_load ? '0 : w_cnt_q;
    w_sel   = w_q[x_cnt_q];
    prod    = bus.i_x * w_sel;
    acc_d   = ((x_cnt_q == '0) ? ACC_BW'(bus.i_psum) : acc_q) + ACC_BW'(prod);
    relu_d  = (x_cnt_q == '0) ? bus.i_relu : relu_q;
    y_d     = relu_fn(sat_fn(acc_d), relu_d);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      for (int i = 0; i < TAPS; i++) w_q[i] <= '0;
      w_cnt_q <= '0;
      x_cnt_q <= '0;
      acc_q   <= '0;
      relu_q  <= 1'b0;
      y_q     <= '0;
      y_vld_q <= 1'b0;
    end else begin
      if (y_vld_q && bus.i_y_ready) y_vld_q <= 1'b0;

      if (x_fire) begin
        acc_q   <= acc_d;
        relu_q  <= relu_d;
        x_cnt_q <= x_last ? '0 : x_cnt_q + 1'b1;
        if (x_last) begin
          y_q     <= y_d;
          y_vld_q <= 1'b1;
        end
      end

      // A load request restarts the weight set and drops any half-accumulated window.
      if (bus.i_w_load) begin
        state_q <= LOAD;
        w_cnt_q <= '0;
        x_cnt_q <= '0;
        acc_q   <= '0;
      end

      if (w_fire) begin
        w_q[w_idx] <= bus.i_w;
        if (w_idx == LAST_TAP) begin
          state_q <= RUN;
          w_cnt_q <= '0;
        end else begin
          w_cnt_q <= w_idx + 1'b1;
        end
      end
    end
  end

  assign bus.o_x_ready = x_rdy;
  assign bus.o_y_valid = y_vld_q;
  assign bus.o_y       = y_q;
  assign bus.o_w_ready = (state_q == RUN);

endmodule
